// File: rtl/sha256_digest_tx.sv
// Digest transmitter: captures the final SHA-256 hash and streams it H0-first over valid/ready.
// Optional macro SHA256_DIGEST_SHA224_EN truncates the stream to the top P_NWORDS-1 words.
module sha256_digest_tx #(
  parameter int unsigned P_WIDTH  = 32,
  parameter int unsigned P_NWORDS = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [P_WIDTH*P_NWORDS-1:0]   hash_val,
  input  logic                          hash_load,
  output logic [P_WIDTH-1:0]            tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          tx_last,
  output logic                          tx_done,
  output logic                          busy,
  output logic                          ovf
);

  localparam int unsigned LW = P_WIDTH * P_NWORDS;
  localparam int unsigned IW = (P_NWORDS > 1) ? $clog2(P_NWORDS) : 1;
`ifdef SHA256_DIGEST_SHA224_EN
  localparam logic [IW-1:0] LAST_IDX = IW'(P_NWORDS - 2);
`else
  localparam logic [IW-1:0] LAST_IDX = IW'(P_NWORDS - 1);
`endif

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t          r_state, w_next;
  logic [LW-1:0]   r_hold;
  logic [IW-1:0]   r_idx;
  logic            r_done;
  logic            r_ovf;

  logic w_last, w_accept, w_final, w_capture, w_drop;

  assign w_last    = (r_state == S_SEND) && (r_idx == LAST_IDX);
  assign w_accept  = (r_state == S_SEND) && tx_ready;
  assign w_final   = w_accept && w_last;
  // A load coinciding with the final accepted beat chains straight into the next digest.
  assign w_capture = hash_load && ((r_state == S_IDLE) || w_final);
  assign w_drop    = hash_load && !w_capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (hash_load) w_next = S_SEND;
      S_SEND: if (w_final && !hash_load) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold <= '0;
      r_idx  <= '0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_done <= w_final;
      if (w_drop) r_ovf <= 1'b1;
      if (w_capture) begin
        r_hold <= hash_val;
        r_idx  <= '0;
      end else if (w_accept) begin
        r_hold <= r_hold << P_WIDTH;
        if (!w_last) r_idx <= r_idx + IW'(1);
      end
    end
  end

  // The current word always sits in the top slot of the shifting holding register.
  assign tx_data  = r_hold[LW-1 -: P_WIDTH];
  assign tx_valid = (r_state == S_SEND);
  assign busy     = (r_state == S_SEND);
  assign tx_last  = w_last;
  assign tx_done  = r_done;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_sha256_digest_tx.sv
// Bench for sha256_digest_tx: queue-based reference model checked every cycle plus literal checks.
// Honours SHA256_DIGEST_SHA224_EN the same way as the design.
module tb_sha256_digest_tx;

`ifdef SHA256_DIGEST_SHA224_EN
  localparam int NS = 7;
`else
  localparam int NS = 8;
`endif

  localparam logic [255:0] D_ABC  = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_ONES = {8{32'h11111111}};
  localparam logic [255:0] D_DEAD = {8{32'hdeadbeef}};
  localparam logic [255:0] D_224  = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] hash_val = '0;
  logic         hash_load = 1'b0;
  logic [31:0]  tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic         tx_last;
  logic         tx_done;
  logic         busy;
  logic         ovf;

  sha256_digest_tx #(.P_WIDTH(32), .P_NWORDS(8)) dut (
    .clk(clk), .reset(reset), .hash_val(hash_val), .hash_load(hash_load),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_last(tx_last), .tx_done(tx_done), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of words still to be delivered.
  logic [31:0] q[$];
  logic        m_done = 1'b0;
  logic        m_ovf  = 1'b0;
  logic [31:0] rx[$];
  bit          rxl[$];
  bit          chk_en = 1'b0;

  function automatic logic [31:0] word_of(input logic [255:0] d, input int i);
    return 32'(d >> (32 * (7 - i)));
  endfunction

  // Inputs settle at negedge+2; sample just before the rising edge.
  always @(negedge clk) begin
    #4;
    if (reset) begin
      q.delete();
      m_done = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      bit acc, fin;
      if (tx_valid && tx_ready) begin
        rx.push_back(tx_data);
        rxl.push_back(tx_last);
      end
      acc    = (q.size() > 0) && tx_ready;
      fin    = acc && (q.size() == 1);
      m_done = fin;
      if (acc) void'(q.pop_front());
      if (hash_load) begin
        if (q.size() == 0) for (int i = 0; i < NS; i++) q.push_back(word_of(hash_val, i));
        else m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && chk_en) begin
      chk("valid", {31'd0, tx_valid}, {31'd0, q.size() != 0});
      chk("busy",  {31'd0, busy},     {31'd0, q.size() != 0});
      chk("last",  {31'd0, tx_last},  {31'd0, q.size() == 1});
      chk("done",  {31'd0, tx_done},  {31'd0, m_done});
      chk("ovf",   {31'd0, ovf},      {31'd0, m_ovf});
      if (q.size() != 0) chk("data", tx_data, q[0]);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic load(input logic [255:0] d);
    hash_val  = d;
    hash_load = 1'b1;
    cyc();
    hash_load = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (!tx_valid) begin ok = 1'b1; break; end
      cyc();
    end
    chk("drain_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic check_rx(input logic [255:0] d, input int n);
    chk("nbeats", 32'(rx.size()), 32'(n));
    for (int i = 0; i < rx.size() && i < n; i++) begin
      chk("rx_word", rx[i], word_of(d, i));
      chk("rx_last", {31'd0, rxl[i]}, {31'd0, i == n - 1});
    end
    rx.delete();
    rxl.delete();
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_data"}, tx_data, 32'd0);
    chk({nm, "_ctl"}, {26'd0, tx_valid, tx_last, tx_done, busy, ovf, 1'b0}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_zero("reset");
    cyc();
    reset = 1'b0;
    rx.delete();
    rxl.delete();
    cyc();
  endtask

  initial begin
    int zeros;
    logic [31:0] held;
    #1;
    check_zero("por");
    cyc();
    reset  = 1'b0;
    chk_en = 1'b1;
    cyc();

    // 1: back-to-back stream with the consumer always ready
    tx_ready = 1'b1;
    load(D_ABC);
    chk("t1_first_valid", {31'd0, tx_valid}, 32'd1);
    chk("t1_first_data", tx_data, 32'hba7816bf);
    for (int i = 1; i < NS; i++) cyc();
    chk("t1_last_flag", {31'd0, tx_last}, 32'd1);
    chk("t1_last_data", tx_data, word_of(D_ABC, NS - 1));
    cyc();
    chk("t1_done", {31'd0, tx_done}, 32'd1);
    chk("t1_busy_low", {31'd0, busy}, 32'd0);
    chk("t1_valid_low", {31'd0, tx_valid}, 32'd0);
    check_rx(D_ABC, NS);
    cyc();

    // 2: random stalls of at most 5 cycles
    tx_ready = 1'b0;
    load(D_ABC);
    zeros = 0;
    for (int k = 0; k < 200 && tx_valid; k++) begin
      tx_ready = (zeros >= 5) ? 1'b1 : 1'($urandom_range(0, 1));
      zeros = tx_ready ? 0 : zeros + 1;
      held = tx_data;
      cyc();
      if (!tx_ready && !reset) chk("t2_stall_hold", tx_data, held);
    end
    tx_ready = 1'b1;
    wait_idle();
    check_rx(D_ABC, NS);
    cyc();

    // 3: load arriving mid-stream is dropped and flagged
    load(D_ABC);
    for (int i = 0; i < 3; i++) cyc();
    chk("t3_at_word3", tx_data, 32'h5dae2223);
    load(D_ONES);
    chk("t3_ovf", {31'd0, ovf}, 32'd1);
    wait_idle();
    check_rx(D_ABC, NS);
    for (int i = 0; i < 4; i++) cyc();
    chk("t3_ovf_sticky", {31'd0, ovf}, 32'd1);
    do_reset();

    // 4: load coincident with the final accepted beat chains without a bubble
    tx_ready = 1'b1;
    load(D_ABC);
    for (int i = 1; i < NS; i++) cyc();
    load(D_DEAD);
    chk("t4_valid", {31'd0, tx_valid}, 32'd1);
    chk("t4_data", tx_data, 32'hdeadbeef);
    chk("t4_done", {31'd0, tx_done}, 32'd1);
    chk("t4_ovf", {31'd0, ovf}, 32'd0);
    wait_idle();
    chk("t4_total_beats", 32'(rx.size()), 32'(2 * NS));
    rx.delete();
    rxl.delete();
    cyc();

    // 5: asynchronous reset while stalled at idx 4
    load(D_ABC);
    for (int i = 0; i < 4; i++) cyc();
    tx_ready = 1'b0;
    cyc();
    cyc();
    chk("t5_stalled_word", tx_data, 32'hb00361a3);
    do_reset();
    tx_ready = 1'b1;
    load(D_ABC);
    chk("t5_restart_data", tx_data, 32'hba7816bf);
    wait_idle();
    check_rx(D_ABC, NS);
    cyc();

`ifdef SHA256_DIGEST_SHA224_EN
    // 6: SHA-224 truncation never presents H7
    load(D_224);
    wait_idle();
    check_rx(D_224, 7);
    cyc();
`endif

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
